// File: rtl/arbiter_pkg.sv
// Shared types for the instruction memory arbiter: the load/run mode enum
// and a small wrap-around increment used for the round-robin pointer.
package arbiter_pkg;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: returns the first asserted request found when
// scanning ptr, ptr+1, ... modulo N_REQ, as both a one-hot grant and an index.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    localparam int SUM_W = PTR_W + 1;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [SUM_W-1:0]   sum;

    // Rotating the doubled vector puts the pointer position at bit 0, so the
    // lowest set bit of req_rot is the winner's offset from ptr.
    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> ptr);

    always_comb begin
        grant = '0;
        idx   = '0;
        sum   = '0;
        any   = |req_rot;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sum = SUM_W'(ptr) + SUM_W'(i);
            end
        end
        if (sum >= SUM_W'(N_REQ)) begin
            sum = sum - SUM_W'(N_REQ);
        end
        idx = sum[PTR_W-1:0];
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/instr_memory_arbiter.sv
// Instruction memory arbiter: host program-load writes in S_LOAD, round-robin
// single-cycle read grants among fetch requesters in S_RUN.
module instr_memory_arbiter
    import arbiter_pkg::*;
#(
    parameter int N_REQ             = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [MEMORY_WIDTH-1:0]            req_data,
    output logic [N_REQ-1:0]                   req_data_valid,
    input  logic                               host_load_start,
    input  logic                               host_load_done,
    input  logic                               host_wr_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0]       host_wr_addr,
    input  logic [MEMORY_WIDTH-1:0]            host_wr_data,
    output logic                               host_wr_ready,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
    output logic [MEMORY_WIDTH-1:0]            mem_wdata,
    input  logic [MEMORY_WIDTH-1:0]            mem_rdata,
    output logic                               loaded
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]       req_data_valid_q, req_data_valid_d;
    logic                   loaded_q, loaded_d;

    logic [N_REQ-1:0]             grant;
    logic [PTR_W-1:0]             grant_idx;
    logic                         grant_any;
    logic [MEMORY_ADDR_WIDTH-1:0] sel_addr;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

    // Grants are still honoured in the cycle host_load_start arrives; the
    // mode switch only takes effect from the next cycle.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        req_data_valid_d = '0;
        req_ready        = '0;
        host_wr_ready    = 1'b0;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        unique case (state_q)
            S_LOAD: begin
                host_wr_ready = 1'b1;
                if (host_wr_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = host_wr_addr;
                    mem_wdata = host_wr_data;
                end
                if (host_load_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (grant_any) begin
                    req_ready        = grant;
                    mem_en           = 1'b1;
                    mem_addr         = sel_addr;
                    req_data_valid_d = grant;
                    rr_ptr_d         = PTR_W'(wrap_inc(int'(grant_idx), N_REQ));
                end
                if (host_load_start) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        loaded_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_LOAD;
            rr_ptr_q         <= '0;
            req_data_valid_q <= '0;
            loaded_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            req_data_valid_q <= req_data_valid_d;
            loaded_q         <= loaded_d;
        end
    end

    assign req_data       = mem_rdata;
    assign req_data_valid = req_data_valid_q;
    assign loaded         = loaded_q;

endmodule
